// File: rtl/ebpf_bswap_pkg.sv
// Shared constants, entry payload and byte-reversal helper for the eBPF
// byte-swap pipeline.
package ebpf_bswap_pkg;

  // ALU control encodings for the endian ops
  localparam logic [3:0] ALU_TO_LE = 4'hD;
  localparam logic [3:0] ALU_TO_BE = 4'hE;

  // Legal swap widths as carried on the 32-bit imm field
  localparam logic [31:0] BSW16 = 32'd16;
  localparam logic [31:0] BSW32 = 32'd32;
  localparam logic [31:0] BSW64 = 32'd64;

  // Upper bounds on the parametrised fields stored in an entry
  localparam int unsigned DATA_MAX_W = 64;
  localparam int unsigned TAG_MAX_W  = 16;
  localparam int unsigned ERRC_W     = 16;

  // One queued result: narrower configurations zero-extend into it
  typedef struct packed {
    logic [DATA_MAX_W-1:0] dst;
    logic                  err;
    logic [TAG_MAX_W-1:0]  tag;
  } bswap_entry_t;

  // Reverse the low nbytes bytes of v; bytes above nbytes come back zero
  function automatic logic [63:0] reverse_low_bytes(input logic [63:0] v,
                                                    input int unsigned nbytes);
    logic [63:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < nbytes) r[8*b +: 8] = v[8*(nbytes-1-b) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ebpf_bswap_fifo.sv
// Generic DEPTH x W synchronous FIFO with count-based full/empty flags.
// Ports: clk, rst_n (async active-low), i_push/i_data write side,
//        i_pop read side, o_data head entry, o_full/o_empty registered flags.
// Pushes while full and pops while empty are ignored.
module ebpf_bswap_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Occupancy after this edge; drives both the count and the flag registers
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Storage, pointers (power-of-two DEPTH so they wrap naturally) and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/ebpf_byteswap_pipe.sv
// Pipelined eBPF le16/32/64 and be16/32/64 unit with error decode, tag
// pass-through and a result FIFO behind a valid/ready handshake.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, src, imm (swap width), alu_ctrl, tag_in  - op side
//        out_valid/out_ready, dst, err, tag_out                     - result side
//        err_count - saturating count of accepted erroneous ops
module ebpf_byteswap_pipe
  import ebpf_bswap_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src,
  input  logic [31:0]       imm,
  input  logic [3:0]        alu_ctrl,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dst,
  output logic              err,
  output logic [TAG_W-1:0]  tag_out,
  output logic [15:0]       err_count
);

  localparam int unsigned ENTRY_W = $bits(bswap_entry_t);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("ebpf_byteswap_pipe: DATA_W must be 32 or 64");
  end
  if (TAG_W > TAG_MAX_W || TAG_W == 0) begin : g_bad_tag_w
    $error("ebpf_byteswap_pipe: TAG_W out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ebpf_byteswap_pipe: DEPTH must be a power of two >= 2");
  end

  logic              r_live;
  logic [ERRC_W-1:0] r_err_count;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_pop;
  logic [63:0]       w_src64;
  logic [63:0]       w_res64;
  logic              w_width_ok;
  logic              w_ctrl_ok;
  logic              w_err;
  bswap_entry_t      w_entry;
  bswap_entry_t      w_head;
  logic [ENTRY_W-1:0] w_head_bits;
  logic              w_unused_head;

  // Holds in_ready low through reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  assign in_ready = r_live && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  assign w_src64 = 64'(src);

  // Swap/decode: widths above DATA_W and unknown controls are exceptions
  always_comb begin
    w_res64    = '0;
    w_width_ok = 1'b0;
    w_ctrl_ok  = (alu_ctrl == ALU_TO_LE) || (alu_ctrl == ALU_TO_BE);
    case (imm)
      BSW16: begin
        w_width_ok = 1'b1;
        w_res64    = (alu_ctrl == ALU_TO_BE) ? reverse_low_bytes(w_src64, 2)
                                             : 64'(w_src64[15:0]);
      end
      BSW32: begin
        w_width_ok = 1'b1;
        w_res64    = (alu_ctrl == ALU_TO_BE) ? reverse_low_bytes(w_src64, 4)
                                             : 64'(w_src64[31:0]);
      end
      BSW64: begin
        w_width_ok = (DATA_W == 64);
        w_res64    = (alu_ctrl == ALU_TO_BE) ? reverse_low_bytes(w_src64, 8)
                                             : w_src64;
      end
      default: w_width_ok = 1'b0;
    endcase
    w_err = !(w_width_ok && w_ctrl_ok);
  end

  always_comb begin
    w_entry     = '0;
    w_entry.dst = w_err ? '0 : w_res64;
    w_entry.err = w_err;
    w_entry.tag = TAG_MAX_W'(tag_in);
  end

  // Saturating error counter on accepted ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && w_err && (r_err_count != {ERRC_W{1'b1}})) begin
      r_err_count <= r_err_count + ERRC_W'(1);
    end
  end

  ebpf_bswap_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head = bswap_entry_t'(w_head_bits);

  // Zero-extension padding in the entry is never read back
  assign w_unused_head = ^w_head_bits;

  assign out_valid = !w_empty;
  assign dst       = w_head.dst[DATA_W-1:0];
  assign err       = w_head.err;
  assign tag_out   = w_head.tag[TAG_W-1:0];
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ebpf_byteswap_pipe.sv
// Self-checking bench for ebpf_byteswap_pipe: directed endian cases, error
// decode, backpressure, random streaming and mid-traffic reset.
module tb_ebpf_byteswap_pipe;

  logic        clk;
  logic        rst_n;

  // 64-bit datapath instance
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src;
  logic [31:0] imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dst;
  logic        err;
  logic [4:0]  tag_out;
  logic [15:0] err_count;

  // 32-bit datapath instance
  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] src32;
  logic [31:0] imm32;
  logic [3:0]  alu_ctrl32;
  logic [4:0]  tag_in32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] dst32;
  logic        err32;
  logic [4:0]  tag_out32;
  logic [15:0] err_count32;

  int checks;
  int failures;
  int exp_errc;

  ebpf_byteswap_pipe #(.DATA_W(64), .TAG_W(5), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .src(src), .imm(imm),
    .alu_ctrl(alu_ctrl), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .dst(dst), .err(err),
    .tag_out(tag_out), .err_count(err_count)
  );

  ebpf_byteswap_pipe #(.DATA_W(32), .TAG_W(5), .DEPTH(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .src(src32), .imm(imm32),
    .alu_ctrl(alu_ctrl32), .tag_in(tag_in32),
    .out_valid(out_valid32), .out_ready(out_ready32), .dst(dst32), .err(err32),
    .tag_out(tag_out32), .err_count(err_count32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, dst} from the endian-op rules, byte by byte
  function automatic logic [64:0] model(input logic [63:0] s, input logic [31:0] w,
                                        input logic [3:0] c, input int dw);
    logic [63:0] r;
    int nb;
    bit ok;
    ok = ((w == 32'd16) || (w == 32'd32) || (w == 32'd64 && dw == 64)) &&
         ((c == 4'hD) || (c == 4'hE));
    if (!ok) return {1'b1, 64'd0};
    nb = int'(w) / 8;
    r  = '0;
    for (int i = 0; i < nb; i++) begin
      if (c == 4'hD) r[8*i +: 8] = s[8*i +: 8];
      else           r[8*(nb-1-i) +: 8] = s[8*i +: 8];
    end
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Offer one op (caller sits just after an edge); returns just after the next edge
  task automatic send(input logic [63:0] s, input logic [31:0] w,
                      input logic [3:0] c, input logic [4:0] t);
    logic [64:0] m;
    m = model(s, w, c, 64);
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    in_valid = 1'b1; src = s; imm = w; alu_ctrl = c; tag_in = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (m[64] && exp_errc < 16'hFFFF) exp_errc++;
  endtask

  initial begin
    logic [63:0] s1, s2, s3, sr;
    logic [64:0] m, e1, e2, e3;
    logic [31:0] w;
    logic [3:0]  c;
    logic [4:0]  t;

    checks = 0; failures = 0; exp_errc = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; src = '0; imm = '0; alu_ctrl = '0; tag_in = '0; out_ready = 1'b0;
    in_valid32 = 1'b0; src32 = '0; imm32 = '0; alu_ctrl32 = '0; tag_in32 = '0;
    out_ready32 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_dst",       dst,            64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_tag_out",   64'(tag_out),   64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst_n = 1'b1;
    chk("in_ready_before_first_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_first_edge", 64'(in_ready), 64'd1);

    // Directed endian ops from the test plan
    out_ready = 1'b1;
    s1 = 64'h0123456789ABCDEF;
    send(s1, 32'd16, 4'hE, 5'd1);
    chk("be16_valid", 64'(out_valid), 64'd1);
    chk("be16_dst", dst, 64'hEFCD);
    chk("be16_err", 64'(err), 64'd0);
    chk("be16_tag", 64'(tag_out), 64'd1);
    send(s1, 32'd32, 4'hE, 5'd2);
    chk("be32_dst", dst, 64'hEFCDAB89);
    chk("be32_err", 64'(err), 64'd0);
    send(s1, 32'd64, 4'hE, 5'd3);
    chk("be64_dst", dst, 64'hEFCDAB8967452301);
    chk("be64_err", 64'(err), 64'd0);
    send(s1, 32'd16, 4'hD, 5'd4);
    chk("le16_dst", dst, 64'hCDEF);
    send(s1, 32'd32, 4'hD, 5'd5);
    chk("le32_dst", dst, 64'h89ABCDEF);
    send(s1, 32'd64, 4'hD, 5'd6);
    chk("le64_dst", dst, s1);
    chk("le64_tag", 64'(tag_out), 64'd6);

    // Error decode
    send(s1, 32'd8, 4'hE, 5'd7);
    chk("err_imm8_err", 64'(err), 64'd1);
    chk("err_imm8_dst", dst, 64'd0);
    chk("err_imm8_count", 64'(err_count), 64'd1);
    send(s1, 32'd16, 4'h4, 5'd8);
    chk("err_ctrl_err", 64'(err), 64'd1);
    chk("err_ctrl_count", 64'(err_count), 64'd2);
    @(posedge clk); #1;
    chk("drained_after_directed", 64'(out_valid), 64'd0);

    // 32-bit datapath: imm 64 is illegal, imm 32 BE is legal
    in_valid32 = 1'b1; src32 = 32'h89ABCDEF; imm32 = 32'd64; alu_ctrl32 = 4'hE; tag_in32 = 5'd9;
    @(posedge clk); #1;
    chk("dw32_imm64_err", 64'(err32), 64'd1);
    chk("dw32_imm64_dst", 64'(dst32), 64'd0);
    chk("dw32_imm64_count", 64'(err_count32), 64'd1);
    imm32 = 32'd32; tag_in32 = 5'd10;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    chk("dw32_be32_dst", 64'(dst32), 64'hEFCDAB89);
    chk("dw32_be32_err", 64'(err32), 64'd0);
    chk("dw32_be32_tag", 64'(tag_out32), 64'd10);

    // Backpressure: DEPTH 2, tags 1..3 back to back with the consumer stalled
    out_ready = 1'b0;
    s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom}; s3 = {$urandom, $urandom};
    e1 = model(s1, 32'd64, 4'hE, 64);
    e2 = model(s2, 32'd32, 4'hD, 64);
    e3 = model(s3, 32'd16, 4'hE, 64);
    in_valid = 1'b1; src = s1; imm = 32'd64; alu_ctrl = 4'hE; tag_in = 5'd1;
    chk("bp_ready_0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    src = s2; imm = 32'd32; alu_ctrl = 4'hD; tag_in = 5'd2;
    chk("bp_ready_1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    src = s3; imm = 32'd16; alu_ctrl = 4'hE; tag_in = 5'd3;
    for (int k = 0; k < 3; k++) begin
      chk("bp_ready_full", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_tag", 64'(tag_out), 64'd1);
      chk("bp_hold_dst", dst, e1[63:0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_out_tag1", 64'(tag_out), 64'd1);
    @(posedge clk); #1;
    chk("bp_out_valid2", 64'(out_valid), 64'd1);
    chk("bp_out_tag2", 64'(tag_out), 64'd2);
    chk("bp_out_dst2", dst, e2[63:0]);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_out_valid3", 64'(out_valid), 64'd1);
    chk("bp_out_tag3", 64'(tag_out), 64'd3);
    chk("bp_out_dst3", dst, e3[63:0]);
    @(posedge clk); #1;
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Random streaming at full rate with the consumer always ready
    for (int n = 0; n < 100; n++) begin
      sr = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: w = 32'd16;
        1: w = 32'd32;
        2: w = 32'd64;
        3: w = 32'd64;
        4: w = 32'd8;
        default: w = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = 4'hD;
        4, 5, 6, 7: c = 4'hE;
        default: c = 4'($urandom);
      endcase
      t = 5'($urandom);
      m = model(sr, w, c, 64);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; src = sr; imm = w; alu_ctrl = c; tag_in = t;
      @(posedge clk); #1;
      if (m[64]) exp_errc++;
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_dst", dst, m[63:0]);
      chk("stream_err", 64'(err), 64'(m[64]));
      chk("stream_tag", 64'(tag_out), 64'(t));
    end
    in_valid = 1'b0;
    chk("stream_err_count", 64'(err_count), 64'(exp_errc));
    @(posedge clk); #1;
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Reset with two entries queued
    out_ready = 1'b0;
    send({$urandom, $urandom}, 32'd32, 4'hE, 5'd11);
    send({$urandom, $urandom}, 32'd8, 4'hD, 5'd12);
    chk("pre_rst_ready", 64'(in_ready), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_dst", dst, 64'd0);
    exp_errc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_ready_high", 64'(in_ready), 64'd1);
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    s1 = {$urandom, $urandom};
    m = model(s1, 32'd64, 4'hE, 64);
    send(s1, 32'd64, 4'hE, 5'd13);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_dst", dst, m[63:0]);
    chk("post_rst_tag", 64'(tag_out), 64'd13);
    chk("post_rst_err_count", 64'(err_count), 64'(exp_errc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
